// File: rtl/par_ser_stream_if.sv
// Word-in / bit-out stream bundle for par_ser_stream.
// The producer drives the parallel side and bit_en; the converter answers on the serial side.
interface par_ser_stream_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] d_in;
    logic             bit_en;
    logic             d_out;
    logic             out_valid;
    logic             out_first;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, d_in, bit_en,
        input  in_ready, d_out, out_valid, out_first, out_last, busy
    );

    modport slave (
        input  in_valid, d_in, bit_en,
        output in_ready, d_out, out_valid, out_first, out_last, busy
    );
endinterface

// File: rtl/par_ser_stream.sv
// Double-buffered parallel-to-serial converter.
// A holding register lets the next word load with no idle bit between words.
module par_ser_stream #(
    parameter int unsigned WIDTH      = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input logic             clk,
    input logic             rst,
    input logic             flush,
    par_ser_stream_if.slave s
);
    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             d_out_q, d_out_d;
    logic             out_valid_q, out_valid_d;
    logic             out_first_q, out_first_d;
    logic             out_last_q, out_last_d;
    logic             busy_q, busy_d;

    logic in_ready_c;
    logic accept_c;
    logic load_c;

    // Ready depends only on registered hold state and flush.
    assign in_ready_c = !hold_valid_q && !flush;
    assign accept_c   = s.in_valid && in_ready_c;

    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        load_c       = 1'b0;

        if (flush) begin
            state_d      = ST_IDLE;
            hold_valid_d = 1'b0;
            shreg_d      = '0;
            cnt_d        = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    load_c = hold_valid_q;
                end
                ST_SHIFT: begin
                    if (s.bit_en) begin
                        if (cnt_q != LAST_BIT) begin
                            shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                            cnt_d   = cnt_q + CNT_W'(1);
                        end else if (hold_valid_q) begin
                            load_c = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            shreg_d = '0;
                            cnt_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (load_c) begin
                shreg_d      = hold_q;
                cnt_d        = '0;
                state_d      = ST_SHIFT;
                hold_valid_d = 1'b0;
            end

            // Accept never coincides with load: accept needs hold empty, load needs it full.
            if (accept_c) begin
                hold_d       = s.d_in;
                hold_valid_d = 1'b1;
            end
        end

        out_valid_d = (state_d == ST_SHIFT);
        d_out_d     = out_valid_d ? (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]) : IDLE_LEVEL;
        out_first_d = out_valid_d && (cnt_d == '0);
        out_last_d  = out_valid_d && (cnt_d == LAST_BIT);
        busy_d      = out_valid_d || hold_valid_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            d_out_q      <= IDLE_LEVEL;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            d_out_q      <= d_out_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
            busy_q       <= busy_d;
        end
    end

    assign s.in_ready  = in_ready_c;
    assign s.d_out     = d_out_q;
    assign s.out_valid = out_valid_q;
    assign s.out_first = out_first_q;
    assign s.out_last  = out_last_q;
    assign s.busy      = busy_q;
endmodule

// File: tb/tb_par_ser_stream.sv
// Bench for par_ser_stream: an 8-bit MSB-first instance and a 5-bit LSB-first instance,
// checked every cycle against a word/bit-index model plus literal stream expectations.
module tb_par_ser_stream;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic flush = 1'b0;
    int   cyc   = 0;
    bit   chk_en = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    par_ser_stream_if #(.WIDTH(8)) b8();
    par_ser_stream_if #(.WIDTH(5)) b5();

    par_ser_stream #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
        .clk(clk), .rst(rst), .flush(flush), .s(b8)
    );
    par_ser_stream #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut5 (
        .clk(clk), .rst(rst), .flush(flush), .s(b5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // 5-bit instance gets a bit tick on every third clock.
    always @(posedge clk) begin
        #1;
        b5.bit_en = ((cyc % 3) == 0);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Model: one optional pending word, one word in flight indexed by bit position (-1 = none).
    localparam int  MW    [2] = '{8, 5};
    localparam bit  MMSB  [2] = '{1'b1, 1'b0};
    localparam bit  MIDLE [2] = '{1'b0, 1'b1};
    int          m_idx  [2];
    logic [31:0] m_cur  [2];
    logic [31:0] m_hold [2];
    bit          m_hv   [2];

    function automatic void m_clear(int k);
        m_idx[k]  = -1;
        m_hv[k]   = 1'b0;
        m_cur[k]  = '0;
        m_hold[k] = '0;
    endfunction

    function automatic void m_step(int k, bit iv, logic [31:0] din, bit be);
        bit acc;
        if (flush) begin
            m_clear(k);
            return;
        end
        acc = iv && !m_hv[k];
        if (m_idx[k] < 0) begin
            if (m_hv[k]) begin
                m_cur[k] = m_hold[k];
                m_idx[k] = 0;
                m_hv[k]  = 1'b0;
            end
        end else if (be) begin
            if (m_idx[k] < MW[k] - 1) begin
                m_idx[k] = m_idx[k] + 1;
            end else if (m_hv[k]) begin
                m_cur[k] = m_hold[k];
                m_idx[k] = 0;
                m_hv[k]  = 1'b0;
            end else begin
                m_idx[k] = -1;
            end
        end
        if (acc) begin
            m_hold[k] = din;
            m_hv[k]   = 1'b1;
        end
    endfunction

    // {d_out, out_valid, out_first, out_last, busy, in_ready}
    function automatic logic [5:0] m_exp(int k);
        bit ov;
        bit dout;
        int pos;
        ov   = (m_idx[k] >= 0);
        pos  = MMSB[k] ? (MW[k] - 1 - m_idx[k]) : m_idx[k];
        dout = ov ? m_cur[k][pos] : MIDLE[k];
        return {dout, ov, ov && (m_idx[k] == 0), ov && (m_idx[k] == MW[k] - 1),
                ov || m_hv[k], !m_hv[k] && !flush};
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_clear(0);
            m_clear(1);
        end else begin
            m_step(0, b8.in_valid, 32'(b8.d_in), b8.bit_en);
            m_step(1, b5.in_valid, 32'(b5.d_in), b5.bit_en);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dut8 outputs vs model",
                32'({b8.d_out, b8.out_valid, b8.out_first, b8.out_last, b8.busy, b8.in_ready}),
                32'(m_exp(0)));
            chk("dut5 outputs vs model",
                32'({b5.d_out, b5.out_valid, b5.out_first, b5.out_last, b5.busy, b5.in_ready}),
                32'(m_exp(1)));
        end
    end

    // Collectors of consumed bits; an epoch bump from the stimulus restarts them.
    int          ep8 = 0, ep8_seen = 0, ep5 = 0, ep5_seen = 0;
    logic [31:0] c8_word, c8_fm, c8_lm, c5_word;
    int          c8_n, c8_c0, c8_c1, nv8, nr8, c5_n, nl5;

    always @(negedge clk) begin
        if (ep8 != ep8_seen) begin
            ep8_seen = ep8;
            c8_word = '0; c8_fm = '0; c8_lm = '0;
            c8_n = 0; c8_c0 = 0; c8_c1 = 0; nv8 = 0; nr8 = 0;
        end
        if (ep5 != ep5_seen) begin
            ep5_seen = ep5;
            c5_word = '0; c5_n = 0; nl5 = 0;
        end
        if (!b8.in_ready) nr8++;
        if (b8.out_valid) begin
            nv8++;
            if (b8.bit_en && c8_n < 32) begin
                c8_word = {c8_word[30:0], b8.d_out};
                c8_fm[c8_n] = b8.out_first;
                c8_lm[c8_n] = b8.out_last;
                if (c8_n == 0) c8_c0 = cyc;
                c8_c1 = cyc;
                c8_n++;
            end
        end
        if (b5.out_valid) begin
            if (b5.out_last) nl5++;
            if (b5.bit_en && c5_n < 32) begin
                c5_word[c5_n] = b5.d_out;
                c5_n++;
            end
        end
    end

    task automatic wait_ready8(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b8.in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) chk({nm, " accept timeout"}, 32'(ok), 32'd1);
    endtask

    task automatic send8(input logic [7:0] w, input bit keep);
        b8.in_valid = 1'b1;
        b8.d_in     = w;
        wait_ready8("send8");
        @(posedge clk); #1;
        if (!keep) b8.in_valid = 1'b0;
    endtask

    task automatic wait_idle8(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!b8.busy) begin ok = 1'b1; break; end
        end
        #1;
        if (!ok) chk({nm, " idle timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0, t1;
        logic [7:0]  acc_w;
        bit          got;
        b8.in_valid = 1'b0; b8.d_in = '0; b8.bit_en = 1'b1;
        b5.in_valid = 1'b0; b5.d_in = '0;

        #2 rst = 1'b0;
        chk_en = 1'b1;
        #1;
        chk("reset dut8", 32'({b8.d_out, b8.out_valid, b8.out_first, b8.out_last, b8.busy, b8.in_ready}), 32'h01);
        chk("reset dut5", 32'({b5.d_out, b5.out_valid, b5.out_first, b5.out_last, b5.busy, b5.in_ready}), 32'h21);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single word 0xA5, MSB first, one bit per clock
        ep8++;
        send8(8'hA5, 1'b0);
        @(negedge clk);
        chk("latency after accept {valid,busy}", 32'({b8.out_valid, b8.busy}), 32'h1);
        @(negedge clk);
        chk("first bit {d_out,valid,first}", 32'({b8.d_out, b8.out_valid, b8.out_first}), 32'h7);
        wait_idle8("single");
        chk("single word bits", c8_word, 32'hA5);
        chk("single word count", 32'(c8_n), 32'd8);
        chk("single first mask", c8_fm, 32'h01);
        chk("single last mask", c8_lm, 32'h80);
        chk("idle {d_out,busy}", 32'({b8.d_out, b8.busy}), 32'h0);

        // Back-to-back 0xA5, 0x3C with no gap
        @(posedge clk); #1;
        ep8++;
        b8.in_valid = 1'b1; b8.d_in = 8'hA5;
        wait_ready8("b2b first");
        @(posedge clk); #1;
        t0 = cyc;
        b8.d_in = 8'h3C;
        wait_ready8("b2b second");
        @(posedge clk); #1;
        t1 = cyc;
        b8.in_valid = 1'b0;
        chk("b2b accept spacing", 32'(t1 - t0), 32'd2);
        wait_idle8("b2b");
        chk("b2b bits", c8_word, 32'hA53C);
        chk("b2b count", 32'(c8_n), 32'd16);
        chk("b2b contiguous span", 32'(c8_c1 - c8_c0), 32'd15);
        chk("b2b in_ready low cycles", 32'(nr8), 32'd8);
        chk("b2b first mask", c8_fm, 32'h0101);
        chk("b2b last mask", c8_lm, 32'h8080);

        // 5-bit LSB-first with bit_en every third clock
        @(posedge clk); #1;
        ep5++;
        b5.in_valid = 1'b1; b5.d_in = 5'b10110;
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b5.in_ready) begin got = 1'b1; break; end
        end
        if (!got) chk("send5 accept timeout", 32'(got), 32'd1);
        @(posedge clk); #1;
        b5.in_valid = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!b5.busy) begin got = 1'b1; break; end
        end
        #1;
        if (!got) chk("dut5 idle timeout", 32'(got), 32'd1);
        chk("lsb5 bits", c5_word, 32'h16);
        chk("lsb5 count", 32'(c5_n), 32'd5);
        chk("lsb5 last held clocks", 32'(nl5), 32'd3);
        chk("lsb5 idle level", 32'(b5.d_out), 32'd1);

        // Backpressure: d_in changes every cycle while the hold register is full
        @(posedge clk); #1;
        ep8++;
        b8.in_valid = 1'b1; b8.d_in = 8'hA5;
        wait_ready8("bp first");
        @(posedge clk); #1;
        b8.d_in = 8'h3C;
        wait_ready8("bp second");
        @(posedge clk); #1;
        got = 1'b0;
        acc_w = '0;
        for (int k = 0; k < 40; k++) begin
            b8.d_in = 8'h40 + 8'(k);
            @(negedge clk);
            if (b8.in_ready) begin got = 1'b1; acc_w = b8.d_in; break; end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        chk("bp accept seen", 32'(got), 32'd1);
        chk("bp accepted word", 32'(acc_w), 32'h47);
        wait_idle8("bp");
        chk("bp bits", c8_word, 32'hA53C47);
        chk("bp count", 32'(c8_n), 32'd24);

        // Asynchronous reset at bit 3 of 0xFF with 0x12 held
        @(posedge clk); #1;
        send8(8'hFF, 1'b1);
        b8.d_in = 8'h12;
        wait_ready8("rst held");
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        @(posedge clk); #2;
        chk("pre-reset {valid,in_ready}", 32'({b8.out_valid, b8.in_ready}), 32'h2);
        rst = 1'b0;
        #1;
        chk("async reset outputs", 32'({b8.d_out, b8.out_valid, b8.out_first, b8.out_last, b8.busy, b8.in_ready}), 32'h01);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        ep8++;
        send8(8'h81, 1'b0);
        wait_idle8("post-reset");
        repeat (4) @(negedge clk);
        #1;
        chk("post-reset bits", c8_word, 32'h81);
        chk("post-reset count", 32'(c8_n), 32'd8);

        // Flush on the last bit with bit_en=1 while a word is held
        @(posedge clk); #1;
        send8(8'h5A, 1'b1);
        b8.d_in = 8'hC3;
        wait_ready8("flush held");
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("pre-flush {valid,last,busy}", 32'({b8.out_valid, b8.out_last, b8.busy}), 32'h7);
        flush = 1'b1;
        #1;
        chk("in_ready during flush", 32'(b8.in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        ep8++;
        @(negedge clk);
        chk("after flush {busy,valid}", 32'({b8.busy, b8.out_valid}), 32'h0);
        repeat (12) @(negedge clk);
        #1;
        chk("no word after flush", 32'(nv8), 32'd0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
